// File: rtl/controlador_pilha_if.sv
// Request/response bus between the control unit (UC) and controlador_pilha.
// master = UC side, slave = controller side.
interface controlador_pilha_if #(
  parameter int LARGURA = 16
);
  logic               req_valid;
  logic               req_ready;
  logic               req_op;
  logic               req_src;
  logic [LARGURA-1:0] din_uc;
  logic [31:0]        din_ula;
  logic               resp_valid;
  logic               resp_ready;
  logic [LARGURA-1:0] resp_data;
  logic               resp_err;

  modport master (
    output req_valid, req_op, req_src, din_uc, din_ula, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_src, din_uc, din_ula, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/controlador_pilha.sv
// controlador_pilha: request-side controller for the hardware stack.
// Accepts push/pop requests, drives one-cycle stack strobes, tracks occupancy
// and returns popped words (or an underflow marker) to the UC.
// Optional build macro PILHA_SATURA_ULA_EN: ULA push word is saturated
// signed 32->LARGURA bits instead of being truncated.
module controlador_pilha #(
  parameter int PROFUNDIDADE = 16,
  parameter int LARGURA      = 16,
  parameter int CW           = $clog2(PROFUNDIDADE + 1)
) (
  input  logic               clk,
  input  logic               rst,
  controlador_pilha_if.slave s,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_sel,
  output logic [LARGURA-1:0] stk_din,
  input  logic [LARGURA-1:0] stk_dout,
  output logic [CW-1:0]      contagem,
  output logic               vazia,
  output logic               cheia,
  output logic               err_overflow,
  output logic               err_underflow
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    EMPILHA    = 3'd1,
    DESEMPILHA = 3'd2,
    ESPERA     = 3'd3,
    RESPOSTA   = 3'd4,
    ERRO_OVF   = 3'd5,
    ERRO_UNF   = 3'd6
  } estado_t;

  localparam logic [CW-1:0] PROF_C = CW'(PROFUNDIDADE);
  localparam logic [CW-1:0] UM_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

  estado_t            r_estado;
  estado_t            w_prox;
  logic [CW-1:0]      r_contagem;
  logic [CW-1:0]      w_cont_prox;
  logic               r_req_ready;
  logic               r_resp_valid;
  logic [LARGURA-1:0] r_resp_data;
  logic               r_resp_err;
  logic               r_stk_push;
  logic               r_stk_pop;
  logic               r_stk_sel;
  logic [LARGURA-1:0] r_stk_din;
  logic               r_err_ovf;
  logic               r_err_unf;
  logic               w_aceita;
  logic [LARGURA-1:0] w_palavra_ula;
  logic [LARGURA-1:0] w_palavra;

`ifdef PILHA_SATURA_ULA_EN
  // Signed saturation: in range only when all bits above the target sign bit
  // replicate the 32-bit sign.
  function automatic logic [LARGURA-1:0] f_satura_ula(input logic [31:0] d);
    logic [32-LARGURA:0] topo;
    topo = d[31:LARGURA-1];
    if (topo == {(33-LARGURA){d[31]}}) begin
      return d[LARGURA-1:0];
    end else if (d[31]) begin
      return {1'b1, {(LARGURA-1){1'b0}}};
    end else begin
      return {1'b0, {(LARGURA-1){1'b1}}};
    end
  endfunction

  assign w_palavra_ula = f_satura_ula(s.din_ula);
`else
  logic w_unused_ula;
  assign w_palavra_ula = s.din_ula[LARGURA-1:0];
  assign w_unused_ula  = ^s.din_ula[31:LARGURA];
`endif

  assign w_aceita  = s.req_valid & r_req_ready & (r_estado == OCIOSO);
  assign w_palavra = s.req_src ? w_palavra_ula : s.din_uc;

  // State register of the request FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next state and next occupancy; occupancy only moves on a legal push/pop.
  always_comb begin
    w_prox      = r_estado;
    w_cont_prox = r_contagem;
    case (r_estado)
      OCIOSO: begin
        if (w_aceita) begin
          if (!s.req_op) begin
            if (r_contagem < PROF_C) begin
              w_prox      = EMPILHA;
              w_cont_prox = r_contagem + UM_C;
            end else begin
              w_prox = ERRO_OVF;
            end
          end else begin
            if (r_contagem != ZERO_C) begin
              w_prox      = DESEMPILHA;
              w_cont_prox = r_contagem - UM_C;
            end else begin
              w_prox = ERRO_UNF;
            end
          end
        end else begin
          w_prox = OCIOSO;
        end
      end
      EMPILHA:    w_prox = OCIOSO;
      DESEMPILHA: w_prox = ESPERA;
      ESPERA:     w_prox = RESPOSTA;
      RESPOSTA: begin
        if (r_resp_valid && s.resp_ready) begin
          w_prox = OCIOSO;
        end else begin
          w_prox = RESPOSTA;
        end
      end
      ERRO_OVF:   w_prox = OCIOSO;
      ERRO_UNF:   w_prox = RESPOSTA;
      default: begin
        w_prox      = OCIOSO;
        w_cont_prox = r_contagem;
      end
    endcase
  end

  // Registered outputs, decoded from the state being entered so every strobe
  // is aligned with the cycle spent in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_contagem   <= ZERO_C;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= {LARGURA{1'b0}};
      r_resp_err   <= 1'b0;
      r_stk_push   <= 1'b0;
      r_stk_pop    <= 1'b0;
      r_stk_sel    <= 1'b0;
      r_stk_din    <= {LARGURA{1'b0}};
      r_err_ovf    <= 1'b0;
      r_err_unf    <= 1'b0;
    end else begin
      r_contagem   <= w_cont_prox;
      r_req_ready  <= (w_prox == OCIOSO);
      r_resp_valid <= (w_prox == RESPOSTA);
      r_stk_push   <= (w_prox == EMPILHA);
      r_stk_pop    <= (w_prox == DESEMPILHA);
      r_err_ovf    <= (w_prox == ERRO_OVF);
      r_err_unf    <= (w_prox == ERRO_UNF);
      if (w_aceita) begin
        r_stk_sel <= s.req_src;
        r_stk_din <= w_palavra;
      end
      // stk_dout is valid during ESPERA; an empty pop answers with zero data.
      if (r_estado == ESPERA) begin
        r_resp_data <= stk_dout;
        r_resp_err  <= 1'b0;
      end else if (r_estado == ERRO_UNF) begin
        r_resp_data <= {LARGURA{1'b0}};
        r_resp_err  <= 1'b1;
      end
    end
  end

  assign s.req_ready    = r_req_ready;
  assign s.resp_valid   = r_resp_valid;
  assign s.resp_data    = r_resp_data;
  assign s.resp_err     = r_resp_err;
  assign stk_push       = r_stk_push;
  assign stk_pop        = r_stk_pop;
  assign stk_sel        = r_stk_sel;
  assign stk_din        = r_stk_din;
  assign contagem       = r_contagem;
  assign vazia          = (r_contagem == ZERO_C);
  assign cheia          = (r_contagem == PROF_C);
  assign err_overflow   = r_err_ovf;
  assign err_underflow  = r_err_unf;

endmodule

// File: doc/controlador_pilha.md
Name: controlador_pilha

Overview:
Request-side controller for the 16x16 hardware stack, sitting between the control unit (UC) and the stack. Accepts push/pop requests from the UC under a valid/ready handshake and selects the UC or ULA data source. Drives one-cycle stack strobes and tracks occupancy, raising overflow/underflow errors. Captures the stack's registered read data and returns it to the UC under a valid/ready response handshake.

Parameters:
PROFUNDIDADE, 16, stack depth in words; must match the stack instance.
LARGURA, 16, stack word width in bits.
CW, $clog2(PROFUNDIDADE+1), occupancy counter width (5 at default).

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  1  0 = push, 1 = pop
req_src  in  1  push source: 0 = din_uc, 1 = din_ula
din_uc  in  LARGURA  push data from the UC
din_ula  in  32  push data from the ULA
resp_valid  out  1  pop result available
resp_ready  in  1  UC accepts the pop result
resp_data  out  LARGURA  popped word
resp_err  out  1  pop result is an underflow (data invalid)
stk_push  out  1  one-cycle write strobe to the stack
stk_pop  out  1  one-cycle read strobe to the stack
stk_sel  out  1  stack source select; copy of latched req_src
stk_din  out  LARGURA  word to write
stk_dout  in  LARGURA  stack read data, registered, valid 1 cycle after stk_pop
contagem  out  CW  current occupancy
vazia  out  1  contagem == 0
cheia  out  1  contagem == PROFUNDIDADE
err_overflow  out  1  one-cycle pulse: push refused
err_underflow  out  1  one-cycle pulse: pop refused

Behaviour:
- Reset (rst=0, async): state OCIOSO, contagem=0, vazia=1. All other outputs 0, including req_ready. req_ready rises the first cycle after rst releases.
- Reset mid-operation: any in-flight request is dropped and no response is issued. Stack contents are treated as discarded.
- All outputs are registered. vazia and cheia are decoded from the contagem register.
- Handshakes:
  - A request is accepted when req_valid & req_ready at a rising edge. req_ready=1 only in OCIOSO.
  - op, src and data are latched at acceptance.
  - A response completes on resp_valid & resp_ready. resp_valid, resp_data and resp_err hold stable until it completes.
- State OCIOSO:
  - On accepted push with contagem<PROFUNDIDADE -> EMPILHA.
  - On accepted push with contagem==PROFUNDIDADE -> ERRO_OVF.
  - On accepted pop with contagem>0 -> DESEMPILHA.
  - On accepted pop with contagem==0 -> ERRO_UNF.
- State EMPILHA (1 cycle): stk_push=1, stk_sel=src, stk_din=word, contagem+1 -> OCIOSO.
- Push word: din_uc if src=0, else din_ula[15:0] (truncation).
- State DESEMPILHA (1 cycle): stk_pop=1, contagem-1 -> ESPERA.
- State ESPERA (1 cycle): capture stk_dout into resp_data, resp_err=0 -> RESPOSTA.
- State RESPOSTA: resp_valid=1 until resp_ready -> OCIOSO (resp_valid=0).
- State ERRO_OVF (1 cycle): err_overflow=1, no stk_push, contagem unchanged -> OCIOSO.
- State ERRO_UNF (1 cycle): err_underflow=1, no stk_pop; load resp_data=0, resp_err=1 -> RESPOSTA. The UC never hangs on an empty pop.
- Latency, with acceptance at edge N:
  - push: stk_push high during cycle N+1; req_ready returns at N+2.
  - pop: stk_pop in cycle N+1, resp_valid from N+3.
  - Back-to-back pushes: one every 2 cycles.
- stk_push and stk_pop are never both 1 in a cycle. contagem never leaves 0..PROFUNDIDADE.
- resp_ready while resp_valid=0 has no effect. req_valid outside OCIOSO is ignored; the request must be held by the UC.

Optional Feature:
PILHA_SATURA_ULA_EN
- Defined: the ULA push word is din_ula saturated as signed 32->16 bits:
  - >32767 -> 16'h7FFF
  - < -32768 -> 16'h8000
  - else din_ula[15:0]
- Undefined: the ULA push word is din_ula[15:0] (plain truncation).
- din_uc is unaffected either way.

Test Plan:
- Reset then push UC 16'hA5A5, push UC 16'h1234, pop, pop -> resp_data 16'h1234 then 16'hA5A5, resp_err=0; contagem 0->1->2->1->0; vazia=1 at end.
- 16 pushes of values 0..15 then a 17th push -> cheia=1 after 16th; 17th gives err_overflow pulse, no stk_push, contagem stays 16; 16 pops return 15..0 in order.
- Pop on empty after reset -> err_underflow pulse, no stk_pop, resp_valid=1 with resp_data=0, resp_err=1; contagem stays 0.
- Push ULA din_ula=32'h0001_8000 -> without macro stk_din=16'h8000; with PILHA_SATURA_ULA_EN stk_din=16'h7FFF; din_ula=32'hFFFF_FFFE -> 16'hFFFE both builds.
- Pop with resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout; completes on resp_ready=1.
- Assert rst=0 mid-pop (during ESPERA) -> outputs clear asynchronously, no response after release, contagem=0, req_ready=1 one cycle after release.
